cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined successor to the team's 32-bit block carry-lookahead adder.
- Adds or subtracts two WIDTH-bit operands using BLK-bit lookahead groups, split across STAGES register stages.
- Uses a valid/ready handshake on input and output.
- Sits in datapaths that need a full-width adder at high clock rate with backpressure.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLK*STAGES.
- BLK, 4, bits per lookahead group; group P/G and group carry are computed in lookahead form.
- STAGES, 2, pipeline stages; each stage resolves WIDTH/STAGES bits (one segment); legal range 1..8.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  asynchronous active-low reset.
- i_valid  in  1  input operands valid.
- o_ready  out  1  block accepts input this cycle.
- i_a  in  WIDTH  operand A.
- i_b  in  WIDTH  operand B.
- i_c  in  1  carry-in; ignored when i_sub=1.
- i_sub  in  1  0: A+B+i_c; 1: A-B, computed as A+~B+1.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_s  out  WIDTH  sum/difference.
- o_c  out  1  carry-out of MSB; for subtract, 1 means no borrow.
- o_ovf  out  1  signed overflow; present only with CLA_PIPE_OVF_EN.

Behaviour:
- Reset (async assert, sync deassert internally not required): all stage valid bits=0, o_valid=0, o_s=0, o_c=0, o_ovf=0, all stage data registers=0.
- Operand B conditioning at input:
  - b_eff = i_sub ? ~i_b : i_b
  - cin = i_sub ? 1 : i_c
- Segment k (k=0..STAGES-1) covers bits [(k+1)*SEG-1 : k*SEG], where SEG=WIDTH/STAGES.
  - Stage k computes segment k from its registered operands and the registered carry of segment k-1.
  - Within a segment, group carries use lookahead, not ripple: c_out = G | (P & c_in) per BLK group, chained through the segment.
- Skewing:
  - Stage 0 computes segment 0 in the accept cycle.
  - Higher segments' operand bits are carried forward in pipeline registers until their stage.
  - Lower sum bits already computed travel forward with them.
- Latency: STAGES cycles from input handshake (i_valid & o_ready) to o_valid=1 with the complete result.
- Throughput: one operation per cycle when i_ready=1.
- Stall rule:
  - stall = o_valid & ~i_ready.
  - While stall=1, every stage register holds its value and o_ready=0.
  - Otherwise o_ready=1; o_ready is combinational from o_valid and i_ready.
  - Bubbles are not compressed.
- Output handshake:
  - o_s, o_c and o_ovf are stable while o_valid=1 and i_ready=0.
  - A result retires on o_valid & i_ready.
- Simultaneous accept and retire in the same cycle is legal; the pipeline shifts by one.
- When i_valid=0 and not stalled, a bubble (valid=0) enters stage 0; data registers may update but must not be observed.
- Wrap-around is modulo 2^WIDTH; overflow is reported only via o_c/o_ovf.
- Reset asserted mid-operation discards all in-flight results immediately; o_valid drops asynchronously.
- STAGES=1: purely registered single-cycle adder with the same handshake.

Optional Feature:
- Macro: CLA_PIPE_OVF_EN.
- Defined:
  - o_ovf port exists and is registered alongside o_s.
  - o_ovf = carry into MSB XOR carry out of MSB, using b_eff.
  - Examples: 0x7FFFFFFF+1 gives o_ovf=1; 0x80000000-1 gives o_ovf=1.
- Undefined:
  - o_ovf port and its logic are absent.
  - All other behaviour is identical.

Test Plan (WIDTH=32, BLK=4, STAGES=2 unless noted):
- Reset: hold i_rstn=0 → o_valid=0, o_s=0, o_c=0, o_ready=1 after release. Assert i_rstn mid-stream → o_valid=0 immediately, no stale result after release.
- Add: A=0xFFFFFFFF, B=0x00000001, i_c=0, i_sub=0, i_ready=1 → 2 cycles later o_s=0x00000000, o_c=1, o_ovf=0.
- Subtract: A=5, B=7, i_sub=1, i_c=1 (ignored) → o_s=0xFFFFFFFE, o_c=0. Then A=0x80000000, B=1, i_sub=1 → o_s=0x7FFFFFFF, o_c=1, o_ovf=1.
- Backpressure: stream 8 back-to-back adds, hold i_ready=0 for 3 cycles once o_valid=1 → o_ready=0 during stall, o_s held, all 8 results in order with none lost or duplicated.
- Cross-segment carry: A=0x0000FFFF, B=0x00000001, i_c=1 → o_s=0x00010001, o_c=0. Repeat for STAGES=1 and STAGES=4 → same result, latency 1 and 4 respectively.
- Random: 10k random A/B/i_c/i_sub with random i_valid/i_ready → every retired result matches the reference model: {o_c,o_s}=A+b_eff+cin.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// Pipelined, parametrised block carry-lookahead adder/subtractor with valid/ready handshake.
// Define CLA_PIPE_OVF_EN to add the registered signed-overflow output o_ovf.
`timescale 1ns/1ps
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_c,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c
`ifdef CLA_PIPE_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / BLK;
    localparam int LAST = STAGES - 1;

    // One segment: each bit carry is formed from its group's carry-in and the
    // prefix generate/propagate, and group carries chain as G | (P & c_in).
    function automatic logic [SEG:0] cla_seg(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           cin);
        logic [SEG-1:0] p;
        logic [SEG-1:0] g;
        logic [SEG-1:0] c;
        logic           gc;
        logic           rg;
        logic           rp;
        p  = a ^ b;
        g  = a & b;
        c  = '0;
        gc = cin;
        for (int grp = 0; grp < NGRP; grp++) begin
            rg = 1'b0;
            rp = 1'b1;
            for (int i = 0; i < BLK; i++) begin
                c[grp*BLK+i] = rg | (rp & gc);
                rg = g[grp*BLK+i] | (p[grp*BLK+i] & rg);
                rp = rp & p[grp*BLK+i];
            end
            gc = rg | (rp & gc);
        end
        return {gc, p ^ c};
    endfunction

    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             c_q   [STAGES];
    logic             v_q   [STAGES];

    logic [WIDTH-1:0] src_a [STAGES];
    logic [WIDTH-1:0] src_b [STAGES];
    logic [WIDTH-1:0] src_s [STAGES];
    logic             src_c [STAGES];
    logic             src_v [STAGES];
    logic [SEG:0]     res   [STAGES];
    logic [WIDTH-1:0] nxt_s [STAGES];
    logic             nxt_c [STAGES];
    logic             stall;

    // Handshake: input is taken on i_valid & o_ready, a result retires on
    // o_valid & i_ready; a held output (o_valid & ~i_ready) freezes every stage.
    assign stall   = v_q[LAST] & ~i_ready;
    assign o_ready = ~stall;
    assign o_valid = v_q[LAST];
    assign o_s     = s_q[LAST];
    assign o_c     = c_q[LAST];

    always_comb begin
        src_a[0] = i_a;
        src_b[0] = i_sub ? ~i_b : i_b;
        src_c[0] = i_sub | i_c;
        src_s[0] = '0;
        src_v[0] = i_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_c[k] = c_q[k-1];
            src_s[k] = s_q[k-1];
            src_v[k] = v_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res[k]   = cla_seg(src_a[k][k*SEG +: SEG], src_b[k][k*SEG +: SEG], src_c[k]);
            nxt_s[k] = src_s[k];
            nxt_s[k][k*SEG +: SEG] = res[k][SEG-1:0];
            nxt_c[k] = res[k][SEG];
        end
    end

`ifdef CLA_PIPE_OVF_EN
    logic ovf_q;
    logic nxt_ovf;
    // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
    assign nxt_ovf = src_a[LAST][WIDTH-1] ^ src_b[LAST][WIDTH-1] ^ nxt_s[LAST][WIDTH-1]
                   ^ nxt_c[LAST];
    assign o_ovf   = ovf_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= nxt_ovf;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (!stall) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= nxt_s[k];
                c_q[k] <= nxt_c[k];
                v_q[k] <= src_v[k];
            end
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed + random bench for cla_pipe_adder with an expected-result queue.
`timescale 1ns/1ps
module tb_cla_pipe_adder;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready = 1'b1;
    logic         i_c = 1'b0;
    logic         i_sub = 1'b0;
    logic [W-1:0] i_a = '0;
    logic [W-1:0] i_b = '0;
    logic         o_ready, o_valid, o_c;
    logic [W-1:0] o_s;
    logic         d1_ready, d1_valid, d1_c, d4_ready, d4_valid, d4_c;
    logic [W-1:0] d1_s, d4_s;
    logic         side_ready = 1'b1;
`ifdef CLA_PIPE_OVF_EN
    logic         o_ovf, d1_ovf, d4_ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [W+1:0] exp_q[$];
    logic         prev_stall = 1'b0;
    logic [W+1:0] prev_word = '0;

    always #5 clk = ~clk;

    cla_pipe_adder #(.WIDTH(W), .BLK(4), .STAGES(2)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub),
        .o_valid(o_valid), .i_ready(i_ready), .o_s(o_s), .o_c(o_c)
`ifdef CLA_PIPE_OVF_EN
        , .o_ovf(o_ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(W), .BLK(4), .STAGES(1)) dut1 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(d1_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub),
        .o_valid(d1_valid), .i_ready(side_ready), .o_s(d1_s), .o_c(d1_c)
`ifdef CLA_PIPE_OVF_EN
        , .o_ovf(d1_ovf)
`endif
    );

    cla_pipe_adder #(.WIDTH(W), .BLK(4), .STAGES(4)) dut4 (
        .i_clk(clk), .i_rstn(rstn), .i_valid(i_valid), .o_ready(d4_ready),
        .i_a(i_a), .i_b(i_b), .i_c(i_c), .i_sub(i_sub),
        .o_valid(d4_valid), .i_ready(side_ready), .o_s(d4_s), .o_c(d4_c)
`ifdef CLA_PIPE_OVF_EN
        , .o_ovf(d4_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [W+1:0] obs, input logic [W+1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {ovf, carry, sum} from plain wide arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c, input logic sub);
        logic [W-1:0] beff;
        logic [W:0]   sum;
        logic         ovf;
        beff = sub ? ~b : b;
        sum  = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, (sub ? 1'b1 : c)};
        ovf  = (a[W-1] == beff[W-1]) && (sum[W-1] != a[W-1]);
        return {ovf, sum};
    endfunction

    function automatic logic [W+1:0] mask(input logic [W+1:0] e);
        logic [W+1:0] m;
        m = e;
`ifndef CLA_PIPE_OVF_EN
        m[W+1] = 1'b0;
`endif
        return m;
    endfunction

    function automatic logic [W+1:0] obs_main();
`ifdef CLA_PIPE_OVF_EN
        return {o_ovf, o_c, o_s};
`else
        return {1'b0, o_c, o_s};
`endif
    endfunction

    // Scoreboard: retire results, check held outputs during a stall.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_word", obs_main(), prev_word);
                chk("hold_valid", {{(W+1){1'b0}}, o_valid}, 1);
            end
            if (o_valid && !i_ready)
                chk("stall_ready", {{(W+1){1'b0}}, o_ready}, 0);
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_out observed=%h expected=none", obs_main());
                end else begin
                    chk("result", obs_main(), mask(exp_q.pop_front()));
                end
            end
            prev_stall = o_valid && !i_ready;
            prev_word  = obs_main();
        end
    end

    task automatic drive(input logic v, input logic r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c, input logic sub,
                         input logic [W+1:0] exp, output logic acc);
        i_valid = v;
        i_ready = r;
        i_a     = a;
        i_b     = b;
        i_c     = c;
        i_sub   = sub;
        @(negedge clk);
        acc = v && o_ready;
        if (acc) exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) drive(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, '0, acc);
    endtask

    initial begin
        logic         acc;
        logic [W-1:0] a, b;
        logic         c, sub;
        int           sent, hold, lat1, lat2, lat4, it;
        logic [W+1:0] s1, s4;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", {{(W+1){1'b0}}, o_valid}, 0);
        chk("rst_s", {2'b00, o_s}, 0);
        chk("rst_c", {{(W+1){1'b0}}, o_c}, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rst_ready", {{(W+1){1'b0}}, o_ready}, 1);
        @(posedge clk);
        #1;

        // Directed add/subtract corners
        drive(1'b1, 1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0}, acc);
        chk("accept_first", {{(W+1){1'b0}}, acc}, 1);
        drive(1'b1, 1'b1, 32'd5, 32'd7, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE}, acc);
        drive(1'b1, 1'b1, 32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF}, acc);
        drive(1'b1, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000}, acc);
        idle(4);
        chk("directed_drained", (W+2)'(exp_q.size()), 0);

        // Backpressure: 8 back-to-back adds, 3-cycle stall once output is valid
        sent = 0;
        hold = 3;
        for (int i = 0; i < 40 && sent < 8; i++) begin
            logic r;
            r = 1'b1;
            if (o_valid && hold > 0) begin
                r = 1'b0;
                hold--;
            end
            a = 32'h1000_0000 * sent + 32'h0000_FFF0;
            b = 32'h0000_0011 + sent;
            drive(1'b1, r, a, b, 1'b0, 1'b0, model(a, b, 1'b0, 1'b0), acc);
            if (acc) sent++;
        end
        chk("bp_sent", (W+2)'(sent), 8);
        idle(6);
        chk("bp_drained", (W+2)'(exp_q.size()), 0);

        // Cross-segment carry and latency for STAGES = 1, 2, 4
        idle(6);
        i_a = 32'h0000_FFFF; i_b = 32'h1; i_c = 1'b1; i_sub = 1'b0;
        i_valid = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        chk("xseg_accept", {{(W+1){1'b0}}, o_ready}, 1);
        exp_q.push_back({2'b00, 32'h0001_0001});
        @(posedge clk);
        #1 i_valid = 1'b0;
        lat1 = 0; lat2 = 0; lat4 = 0; s1 = '1; s4 = '1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (o_valid && lat2 == 0) lat2 = cyc;
            if (d1_valid && lat1 == 0) begin lat1 = cyc; s1 = {1'b0, d1_c, d1_s}; end
            if (d4_valid && lat4 == 0) begin lat4 = cyc; s4 = {1'b0, d4_c, d4_s}; end
            @(posedge clk);
            #1;
        end
        chk("lat_stages1", (W+2)'(lat1), 1);
        chk("lat_stages2", (W+2)'(lat2), 2);
        chk("lat_stages4", (W+2)'(lat4), 4);
        chk("xseg_stages1", s1, {2'b00, 32'h0001_0001});
        chk("xseg_stages4", s4, {2'b00, 32'h0001_0001});

        // Random operands with random valid/ready
        sent = 0;
        it = 0;
        while (sent < 10000 && it < 40000) begin
            a   = $urandom();
            b   = $urandom();
            c   = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'h8000_0000;
                2: begin a = 32'h7FFF_FFFF; b = 32'h0000_0001; end
                default: ;
            endcase
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  a, b, c, sub, model(a, b, c, sub), acc);
            if (acc) sent++;
            it++;
        end
        chk("rand_sent", (W+2)'(sent), 10000);
        idle(8);
        chk("rand_drained", (W+2)'(exp_q.size()), 0);

        // Reset in mid-stream drops in-flight results at once
        drive(1'b1, 1'b1, 32'h1, 32'h2, 1'b0, 1'b0, model(32'h1, 32'h2, 1'b0, 1'b0), acc);
        drive(1'b1, 1'b1, 32'h3, 32'h4, 1'b0, 1'b0, model(32'h3, 32'h4, 1'b0, 1'b0), acc);
        drive(1'b1, 1'b1, 32'h5, 32'h6, 1'b0, 1'b0, model(32'h5, 32'h6, 1'b0, 1'b0), acc);
        i_valid = 1'b0;
        chk("pre_rst_valid", {{(W+1){1'b0}}, o_valid}, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_valid", {{(W+1){1'b0}}, o_valid}, 0);
        chk("rst_async_s", {2'b00, o_s}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rstn = 1'b1;
        idle(6);
        chk("rst_no_stale", (W+2)'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
